// File: rtl/ifetch_if.sv
// Fetch-to-decode handshake bundle.
//   if_valid  fetch -> decode  if_pc/if_inst hold an instruction on offer
//   if_pc     fetch -> decode  PC of the offered instruction
//   if_inst   fetch -> decode  offered instruction word
//   id_ready  decode -> fetch  decode takes the offered instruction this cycle
// The master modport is the fetch side. The slave modport is the decode side.
interface ifetch_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_inst;
    logic            id_ready;

    modport master (output if_valid, if_pc, if_inst, input id_ready);
    modport slave  (input if_valid, if_pc, if_inst, output id_ready);
endinterface

// File: rtl/ifetch.sv
// Fetch stage.
// Generates the PC and drives a synchronous-read instruction memory, which has one
// cycle of read latency. It offers {pc, inst} to decode over a valid/ready
// handshake. A one-entry skid buffer holds a returned word while decode stalls.
// A redirect from execute flushes all fetch state and restarts fetch at the target.
//
// Ports:
//   clk             clock, all state on posedge
//   rst_n           asynchronous active-low reset
//   imem_addr       fetch address (this is pc_q)
//   imem_inst       memory word read at the previous cycle's imem_addr
//   redirect_valid  flush and restart at redirect_pc
//   redirect_pc     redirect target
//   dec             ifetch_if.master: if_valid/if_pc/if_inst out, id_ready in
//   fetch_misalign  sticky misaligned-redirect flag (FETCH_MISALIGN_CHK_EN only)
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN.
// - When the macro is defined, a misaligned redirect target stops fetch and sets
//   fetch_misalign. The flag stays set until an aligned redirect arrives.
// - When the macro is not defined, redirect_pc[1:0] is forced to zero.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int XLEN = 32,
    localparam int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic            fetch_misalign,
`endif
    ifetch_if.master        dec
);

    logic [XLEN-1:0] pc_q;
    logic            f_vld;
    logic [XLEN-1:0] f_pc;
    logic            s_vld;
    logic [XLEN-1:0] s_pc;
    logic [ILEN-1:0] s_inst;

    logic            fire;
    logic            capture;
    logic            s_vld_next;
    logic            issue;
    logic [XLEN-1:0] redir_target;

    assign imem_addr = pc_q;

    assign dec.if_valid = (s_vld | f_vld) & ~redirect_valid;
    assign dec.if_pc    = s_vld ? s_pc : f_pc;
    // The memory returns a word every cycle. When nothing is valid, a zero is
    // shown instead, so that stale data never appears on if_inst.
    assign dec.if_inst  = s_vld ? s_inst : (f_vld ? imem_inst : '0);

    assign fire    = dec.if_valid & dec.id_ready;
    assign capture = ~s_vld & f_vld & ~fire;

    always_comb begin
        s_vld_next = s_vld;
        if (s_vld && fire)
            s_vld_next = 1'b0;
        else if (capture)
            s_vld_next = 1'b1;
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic mis_q;
    logic redir_mis;

    assign redir_mis      = redirect_pc[1:0] != 2'b00;
    assign redir_target   = redirect_pc;
    assign issue          = ~s_vld_next & ~redirect_valid & ~mis_q;
    assign fetch_misalign = mis_q;
`else
    assign redir_target = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
    assign issue        = ~s_vld_next & ~redirect_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            f_vld  <= 1'b0;
            f_pc   <= RESET_PC;
            s_vld  <= 1'b0;
            s_pc   <= '0;
            s_inst <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            mis_q  <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // A redirect takes priority over everything else. Any skid content
            // and any word still in flight from the memory are discarded.
            s_vld <= 1'b0;
            f_vld <= 1'b0;
            pc_q  <= redir_target;
`ifdef FETCH_MISALIGN_CHK_EN
            mis_q <= redir_mis;
            // f_pc is loaded here so that if_pc shows the faulting target.
            if (redir_mis)
                f_pc <= redirect_pc;
`endif
        end else begin
            s_vld <= s_vld_next;
            if (capture) begin
                s_pc   <= f_pc;
                s_inst <= imem_inst;
            end
            // When the skid buffer stays full, the word being read now is
            // dropped. pc_q holds, so the same address is read again on resume.
            if (issue) begin
                f_vld <= 1'b1;
                f_pc  <= pc_q;
                pc_q  <= pc_q + 32'd4;
            end else begin
                f_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_w_n;
    logic [31:0] imem_addr, imem_inst;
    logic [31:0] imem_addr_w, imem_inst_w;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign, fetch_misalign_w;
`endif

    ifetch_if dv();
    ifetch_if dw();

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_misalign (fetch_misalign),
`endif
        .dec            (dv)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_w_n),
        .imem_addr      (imem_addr_w),
        .imem_inst      (imem_inst_w),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_misalign (fetch_misalign_w),
`endif
        .dec            (dw)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        imem_inst   <= mem_word(imem_addr);
        imem_inst_w <= mem_word(imem_addr_w);
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n === 1'b1 && dv.if_valid === 1'b1 && dv.id_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dv_unexpected: got pc %h expected none", dv.if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("dv_pc", dv.if_pc, e);
                chk("dv_inst", dv.if_inst, mem_word(e));
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_w_n === 1'b1 && dw.if_valid === 1'b1 && dw.id_ready === 1'b1) begin
            if (exp_w_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dw_unexpected: got pc %h expected none", dw.if_pc);
            end else begin
                e = exp_w_q.pop_front();
                chk("dw_pc", dw.if_pc, e);
                chk("dw_inst", dw.if_inst, mem_word(e));
            end
        end
    end

    initial begin
        logic [31:0] wexp[4];
        wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        rst_n = 1'b1;
        rst_w_n = 1'b1;
        dv.id_ready = 1'b1;
        dw.id_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        rst_w_n = 1'b0;
        repeat (2) step();

        // reset state
        chk("rst_valid", dv.if_valid, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", dv.if_pc, 32'h0);
        chk("rst_inst", dv.if_inst, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("rst_misalign", fetch_misalign, 0);
`endif

        // stream from reset
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        rst_n = 1'b1;
        step();
        chk("t1_first_valid", dv.if_valid, 1);
        chk("t1_first_pc", dv.if_pc, 32'h0);
        step();
        chk("t1_valid_4", dv.if_valid, 1);
        chk("t1_pc_4", dv.if_pc, 32'h4);

        // stall for 3 cycles at pc 8
        step();
        dv.id_ready = 1'b0;
        chk("t2_valid", dv.if_valid, 1);
        chk("t2_pc", dv.if_pc, 32'h8);
        repeat (2) begin
            step();
            chk("t2_hold_valid", dv.if_valid, 1);
            chk("t2_hold_pc", dv.if_pc, 32'h8);
        end
        step();
        dv.id_ready = 1'b1;
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        chk("t2_resume_pc", dv.if_pc, 32'h8);
        step();
        chk("t2_next_valid", dv.if_valid, 1);
        chk("t2_next_pc", dv.if_pc, 32'hC);
        step();
        chk("t2_next2_valid", dv.if_valid, 1);
        chk("t2_next2_pc", dv.if_pc, 32'h10);

        // redirect while the skid buffer is full
        step();
        dv.id_ready = 1'b0;
        step();
        chk("t3_skid_pc", dv.if_pc, 32'h14);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        #1;
        chk("t3_inval_0", dv.if_valid, 0);
        step();
        redirect_valid = 1'b0;
        dv.id_ready = 1'b1;
        chk("t3_inval_1", dv.if_valid, 0);
        chk("t3_addr", imem_addr, 32'h40);
        exp_q.push_back(32'h40);
        step();
        chk("t3_valid_40", dv.if_valid, 1);
        chk("t3_pc_40", dv.if_pc, 32'h40);
        step();
        dv.id_ready = 1'b0;
        chk("t3_pc_44", dv.if_pc, 32'h44);

        // reset during a stall with the skid buffer full
        step();
        chk("t5_skid_pc", dv.if_pc, 32'h44);
        chk("t5_q_empty", exp_q.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", dv.if_valid, 0);
        chk("t5_rst_pc", dv.if_pc, 32'h0);
        dv.id_ready = 1'b1;
        repeat (2) step();
        chk("t5_rst_hold_valid", dv.if_valid, 0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        rst_n = 1'b1;
        step();
        chk("t5_first_valid", dv.if_valid, 1);
        chk("t5_first_pc", dv.if_pc, 32'h0);
        step();
        chk("t5_pc_4", dv.if_pc, 32'h4);
        step();
        chk("t5_pc_8", dv.if_pc, 32'h8);
        step();
        dv.id_ready = 1'b0;

`ifdef FETCH_MISALIGN_CHK_EN
        // misaligned redirect, then an aligned redirect that recovers
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        dv.id_ready = 1'b1;
        #1;
        chk("t6_redir_valid", dv.if_valid, 0);
        step();
        redirect_valid = 1'b0;
        chk("t6_misalign", fetch_misalign, 1);
        chk("t6_valid", dv.if_valid, 0);
        chk("t6_pc", dv.if_pc, 32'h42);
        step();
        chk("t6_sticky", fetch_misalign, 1);
        chk("t6_sticky_valid", dv.if_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        #1;
        chk("t6_redir2_valid", dv.if_valid, 0);
        step();
        redirect_valid = 1'b0;
        chk("t6_cleared", fetch_misalign, 0);
        chk("t6_gap_valid", dv.if_valid, 0);
        exp_q.push_back(32'h80);
        step();
        chk("t6_valid_80", dv.if_valid, 1);
        chk("t6_pc_80", dv.if_pc, 32'h80);
        step();
        dv.id_ready = 1'b0;
`else
        // the low bits of the redirect target are ignored
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        dv.id_ready = 1'b1;
        #1;
        chk("t6_redir_valid", dv.if_valid, 0);
        step();
        redirect_valid = 1'b0;
        chk("t6_gap_valid", dv.if_valid, 0);
        chk("t6_addr", imem_addr, 32'h40);
        exp_q.push_back(32'h40);
        step();
        chk("t6_valid_40", dv.if_valid, 1);
        chk("t6_pc_40", dv.if_pc, 32'h40);
        step();
        dv.id_ready = 1'b0;
`endif

        // PC wraps modulo 2^32
        for (int i = 0; i < 4; i++) exp_w_q.push_back(wexp[i]);
        rst_w_n = 1'b1;
        dw.id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_valid", dw.if_valid, 1);
            chk("t4_pc", dw.if_pc, wexp[i]);
        end
        step();
        dw.id_ready = 1'b0;

        step();
        chk("end_q_empty", exp_q.size(), 0);
        chk("end_qw_empty", exp_w_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
